// File: rtl/byte_pack56.sv
// Byte-to-word packer: collects NBYTES framed bytes into one word and presents it
// with a single-cycle LOAD pulse; truncated frames raise a sticky frame_err.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | no frame in progress; waiting for a sof byte
//   ST_FILL | frame partially assembled; byte_cnt bytes already held
module byte_pack56 #(
   parameter int NBYTES    = 7,
   parameter int BYTE_W    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [BYTE_W-1:0]          din,
   input  logic                       din_valid,
   input  logic                       sof,
   input  logic                       err_clr,
   output logic [NBYTES*BYTE_W-1:0]   word_out,
   output logic                       LOAD,
   output logic                       busy,
   output logic [2:0]                 byte_cnt,
   output logic                       frame_err
);

   localparam int         WORD_W   = NBYTES * BYTE_W;
   localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   asm_q, asm_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                load_q, load_d;
   logic                err_q, err_d;

   logic                wr_en;
   logic [2:0]          wr_idx;
   logic [2:0]          lane_sel;
   logic                err_set;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         asm_q   <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         asm_q   <= asm_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_d  = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = '0;
      err_set = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (din_valid && sof) begin
               wr_en   = 1'b1;
               cnt_d   = 3'd1;
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (din_valid) begin
               wr_en = 1'b1;
               if (sof) begin
                  // Truncated frame: restart with this byte as byte 0.
                  err_set = 1'b1;
                  cnt_d   = 3'd1;
               end else if (cnt_q == LAST_IDX) begin
                  wr_idx  = cnt_q;
                  load_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  wr_idx = cnt_q;
                  cnt_d  = cnt_q + 3'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Byte k lands in lane (NBYTES-1-k) when MSB first, lane k otherwise.
   always_comb begin
      lane_sel = MSB_FIRST ? (LAST_IDX - wr_idx) : wr_idx;
      asm_d    = asm_q;
      if (wr_en) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (lane_sel == 3'(i)) begin
               asm_d[i*BYTE_W +: BYTE_W] = din;
            end
         end
      end
   end

   always_comb begin
      word_d = word_q;
      if (load_d) begin
         word_d = asm_d;
      end
   end

   always_comb begin
      err_d = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (err_set) begin
         err_d = 1'b1;
      end
   end

   assign word_out  = word_q;
   assign LOAD      = load_q;
   assign busy      = (state_q == ST_FILL);
   assign byte_cnt  = cnt_q;
   assign frame_err = err_q;

endmodule

// File: doc/byte_pack56.md
Name: byte_pack56

Overview:
- Upstream stage of the 56-bit pipeline register, which holds 7 byte lanes and captures on LOAD.
- Accepts a stream of 8-bit bytes framed by a start-of-frame strobe.
- Assembles each group of 7 bytes into one 56-bit word.
- Presents the word with a one-cycle LOAD pulse that drives the register's LOAD and data inputs directly.
- Detects and flags truncated frames.

Parameters:
NBYTES, 7, bytes per word (fixed at 7 for this pipeline; counter width 3).
BYTE_W, 8, bits per byte.
MSB_FIRST, 1, 1 = first byte of frame lands in word_out[55:48]; 0 = first byte lands in word_out[7:0].

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
din  input  8  incoming byte.
din_valid  input  1  din valid this cycle.
sof  input  1  start of frame; meaningful only when din_valid=1; marks byte 0.
err_clr  input  1  clears frame_err.
word_out  output  56  assembled word; drives the register's data input.
LOAD  output  1  one-cycle pulse; word_out is valid and new.
busy  output  1  1 while a frame is partially assembled (state FILL).
byte_cnt  output  3  bytes collected in the current frame (0..6).
frame_err  output  1  sticky error flag, set on a truncated frame.

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: word_out=0, LOAD=0, busy=0, byte_cnt=0, frame_err=0. Internal assembly register = 0. State = IDLE.
- Reset mid-frame: the partial frame is discarded and no LOAD is issued.
- Storage: an internal 56-bit assembly register collects bytes. word_out is a separate holding register, updated only when a frame completes.
- Byte placement, MSB_FIRST=1: byte k goes to bits [55-8k : 48-8k].
- Byte placement, MSB_FIRST=0: byte k goes to bits [8k+7 : 8k].
- IDLE state:
  - din_valid=1, sof=0: byte ignored, no flag.
  - din_valid=1, sof=1: store as byte 0; byte_cnt becomes 1; go to FILL.
- FILL state:
  - din_valid=0: hold. Gaps of any length are legal; there is no timeout.
  - din_valid=1, sof=0, byte_cnt<6: store at index byte_cnt; byte_cnt increments.
  - din_valid=1, sof=0, byte_cnt=6: store as byte 6. On that same edge, word_out takes the complete word (including this byte), LOAD goes to 1, byte_cnt returns to 0, and state returns to IDLE.
  - din_valid=1, sof=1: truncated frame. Set frame_err and discard the partial data; no LOAD is issued. The new byte becomes byte 0, byte_cnt becomes 1, and state stays FILL.
- Latency: LOAD is high in the cycle after the edge that samples the 7th byte. word_out is stable from that cycle until the next LOAD.
- LOAD width: exactly one cycle. LOAD deasserts on the next edge regardless of input.
- Back-to-back frames: a sof byte in the cycle where LOAD is high is accepted normally as byte 0. Minimum frame period is 7 cycles, giving one LOAD per 7 cycles at full rate.
- busy equals (state==FILL). byte_cnt is never 7.
- frame_err: cleared by err_clr=1. If a set event and err_clr occur in the same cycle, set wins.
- Unused assembly bits: none; all 7 lanes are written every frame. Bytes from a discarded frame never reach word_out.

Test Plan:
1. Reset then 7 consecutive bytes 0x11..0x77 (sof on 0x11), MSB_FIRST=1 -> LOAD single pulse 1 cycle after 0x77; word_out=0x11223344556677; busy=0 after.
2. Same stream with MSB_FIRST=0 -> word_out=0x77665544332211.
3. sof frame with din_valid idle gaps of 0,3,1,5 cycles between bytes 0xA0..0xA6 -> one LOAD, word_out=0xA0A1A2A3A4A5A6; byte_cnt steps 1..6 then 0.
4. 4 bytes 0x01..0x04, then sof byte 0xB0 plus 6 bytes 0xB1..0xB6 -> frame_err=1, no LOAD after byte 0x04, single LOAD with word_out=0xB0B1B2B3B4B5B6. Assert err_clr together with a new truncation -> frame_err stays 1. err_clr alone -> frame_err=0.
5. Two frames back-to-back at full rate (14 cycles, sof at cycles 0 and 7) -> LOADs exactly 7 cycles apart. word_out holds frame 1 value until the second LOAD.
6. Assert RESET asynchronously after byte 3 of a frame (between clock edges) -> all outputs 0 immediately. Following non-sof bytes are ignored. A fresh sof frame of 0xC0..0xC6 -> word_out=0xC0C1C2C3C4C5C6.
